mips_boot_loader: RTL and testbench

MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

---
 rtl/mips_boot_pkg.sv | 30 +++
 rtl/mips_boot_cksum.sv | 29 ++
 rtl/mips_boot_loader.sv | 182 ++++++++++++++++++
 tb/tb_mips_boot_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader.
// BOOT_CHECKSUM_EN adds the CKSUM state to the FSM encoding.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
`ifdef BOOT_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'h02;
    localparam logic [7:0] CMD_GO        = 8'hFF;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_CMD = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_CKSUM   = 2'd3;

    function automatic logic is_load(input logic [7:0] cmd);
        return (cmd == CMD_LOAD_IMEM) || (cmd == CMD_LOAD_DMEM);
    endfunction

endpackage

// File: rtl/mips_boot_cksum.sv
// Modulo-256 frame checksum accumulator; only built when BOOT_CHECKSUM_EN is defined.
// zero_o reports whether the running sum plus the byte on data_i wraps to zero.
module mips_boot_cksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       acc_i,
    input  logic [7:0] data_i,
    output logic       zero_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    assign sum_d  = sum_q + data_i;
    assign zero_o = (sum_d == 8'h00);

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else if (clr_i) begin
            sum_q <= acc_i ? data_i : 8'h00;
        end else if (acc_i) begin
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// Byte-stream boot loader: parses load/go frames, writes target memories, releases the core.
// Define BOOT_CHECKSUM_EN to require a trailing zero-sum checksum byte on every load frame.
module mips_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              boot_done,
    output logic              boot_err,
    output logic [1:0]        err_code
);
    import mips_boot_pkg::*;

    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int LEN_BYTES  = LEN_W / 8;
    localparam int CNT_W      = 8;
    localparam int SUM_W      = ADDR_W + LEN_W + 1;

`ifdef BOOT_CHECKSUM_EN
    localparam state_e ST_FRAME_END = ST_CKSUM;
`else
    localparam state_e ST_FRAME_END = ST_IDLE;
`endif

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              rx_ready_q;
    logic              mem_we_q;
    logic              mem_sel_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              cpu_hold_q;
    logic              boot_done_q;
    logic              boot_err_q;
    logic [1:0]        err_code_q;

    logic              accept;
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  len_d;
    logic [SUM_W-1:0]  end_addr;
    logic              over_range;

    assign accept = rx_valid && rx_ready_q;

    // Address and length fields arrive big-endian: shift each new byte in at the bottom.
    assign addr_d     = ADDR_W'({addr_q, rx_data});
    assign len_d      = LEN_W'({len_q, rx_data});
    assign end_addr   = SUM_W'(addr_q) + SUM_W'(len_d);
    assign over_range = end_addr > (SUM_W'(1) << ADDR_W);

`ifdef BOOT_CHECKSUM_EN
    logic ck_zero;

    mips_boot_cksum u_cksum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept && (state_q == ST_IDLE)),
        .acc_i  (accept),
        .data_i (rx_data),
        .zero_o (ck_zero)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cpu_hold_q  <= 1'b1;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            // NOTE: defaults first; later assignments in this block override them, so the
            // write strobe is a one-cycle pulse and rx_ready drops on entry to DONE/ERR.
            mem_we_q   <= 1'b0;
            rx_ready_q <= (state_q != ST_DONE) && (state_q != ST_ERR);
            if (accept) begin
                unique case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        if (is_load(rx_data)) begin
                            sel_q   <= rx_data[1];
                            state_q <= ST_ADDR;
                        end else if (rx_data == CMD_GO) begin
                            state_q     <= ST_DONE;
                            rx_ready_q  <= 1'b0;
                            cpu_hold_q  <= 1'b0;
                            boot_done_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ERR;
                            rx_ready_q <= 1'b0;
                            boot_err_q <= 1'b1;
                            err_code_q <= ERR_BAD_CMD;
                        end
                    end
                    ST_ADDR: begin
                        addr_q <= addr_d;
                        if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                            cnt_q   <= '0;
                            state_q <= ST_LEN;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_LEN: begin
                        len_q <= len_d;
                        if (cnt_q == CNT_W'(LEN_BYTES - 1)) begin
                            cnt_q <= '0;
                            if (over_range) begin
                                state_q    <= ST_ERR;
                                rx_ready_q <= 1'b0;
                                boot_err_q <= 1'b1;
                                err_code_q <= ERR_RANGE;
                            end else if (len_d == '0) begin
                                state_q <= ST_FRAME_END;
                            end else begin
                                state_q <= ST_PAYLOAD;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_PAYLOAD: begin
                        mem_we_q    <= 1'b1;
                        mem_sel_q   <= sel_q;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= rx_data;
                        addr_q      <= addr_q + ADDR_W'(1);
                        len_q       <= len_q - LEN_W'(1);
                        if (len_q == LEN_W'(1)) begin
                            state_q <= ST_FRAME_END;
                        end
                    end
`ifdef BOOT_CHECKSUM_EN
                    ST_CKSUM: begin
                        if (ck_zero) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q    <= ST_ERR;
                            rx_ready_q <= 1'b0;
                            boot_err_q <= 1'b1;
                            err_code_q <= ERR_CKSUM;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign boot_done = boot_done_q;
    assign boot_err  = boot_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: directed frames plus randomized frame sequences
// checked against a frame-level model of expected writes and final status.
`timescale 1ns/1ps
module tb_mips_boot_loader;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              boot_done;
    logic              boot_err;
    logic [1:0]        err_code;

    mips_boot_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .boot_done (boot_done),
        .boot_err  (boot_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q[$];
    wr_t        exp_q[$];
    int         wr_cyc[$];
    logic [7:0] frame_q[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_pass   = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back('{mem_sel, mem_addr, mem_wdata});
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Appends the byte that makes the whole frame sum to zero (optionally corrupted).
    task automatic append_ck(input bit bad);
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] sum = 8'h00;
        foreach (frame_q[i]) sum += frame_q[i];
        sum = 8'h00 - sum;
        if (bad) sum += 8'h01;
        frame_q.push_back(sum);
`else
        if (bad) frame_q.push_back(8'h00);
`endif
    endtask

    task automatic build_load(input logic [7:0] cmd, input int addr, input int len, input bit bad_ck);
        logic [7:0] b;
        logic [15:0] l16;
        l16 = 16'(len);
        frame_q.delete();
        frame_q.push_back(cmd);
        frame_q.push_back(8'(addr));
        frame_q.push_back(l16[15:8]);
        frame_q.push_back(l16[7:0]);
        if (addr + len <= 256) begin
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom);
                frame_q.push_back(b);
                exp_q.push_back('{cmd[1], 8'(addr + k), b});
            end
            append_ck(bad_ck);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, output bit acc);
        int gap;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            if (rx_ready) acc = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, output int n_acc);
        bit acc;
        n_acc = 0;
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], max_gap, acc);
            if (!acc) break;
            n_acc++;
        end
    endtask

    task automatic check_writes(input string tag, input bit back_to_back);
        repeat (2) @(negedge clk);
        check({tag, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_wr"}, wr_q[i], exp_q[i]);
            if (back_to_back && i > 0) check({tag, "_b2b"}, wr_cyc[i] - wr_cyc[i-1], 1);
        end
        wr_q.delete();
        exp_q.delete();
        wr_cyc.delete();
    endtask

    task automatic check_status(input string tag, input logic [1:0] err, input bit done);
        check({tag, "_err_code"}, err_code, err);
        check({tag, "_boot_err"}, boot_err, err != 2'd0);
        check({tag, "_boot_done"}, boot_done, done);
        check({tag, "_cpu_hold"}, cpu_hold, !done);
        check({tag, "_rx_ready"}, rx_ready, (err == 2'd0) && !done);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_sel"}, mem_sel, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
        check({tag, "_boot_done"}, boot_done, 0);
        check({tag, "_boot_err"}, boot_err, 0);
        check({tag, "_err_code"}, err_code, 0);
    endtask

    task automatic release_reset(input string tag);
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_rdy_rise"}, rx_ready, 1);
        wr_q.delete();
        exp_q.delete();
        wr_cyc.delete();
    endtask

    task automatic do_reset(input bit check_vals, input string tag);
        rx_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        if (check_vals) check_reset_vals(tag);
        release_reset(tag);
    endtask

    // Asserts rst between clock edges and checks outputs before any edge occurs.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_vals(tag);
        @(negedge clk);
        release_reset(tag);
    endtask

    bit         acc;
    int         n;
    int         kind, addr, len, exp_n, nf;
    logic [1:0] err;
    bit         done, ck_bad;
    logic [7:0] cmd;

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        do_reset(1, "rst0");

        // Gapless imem load, then dmem load and go.
        frame_q = '{8'h01, 8'h00, 8'h00, 8'h04, 8'h8C, 8'h08, 8'h00, 8'h00};
        append_ck(0);
        exp_q = '{'{1'b0, 8'd0, 8'h8C}, '{1'b0, 8'd1, 8'h08}, '{1'b0, 8'd2, 8'h00}, '{1'b0, 8'd3, 8'h00}};
        exp_n = frame_q.size();
        send_frame(0, n);
        check("imem_acc", n, exp_n);
        check_writes("imem", 1);
        check_status("imem", 2'd0, 0);

        frame_q = '{8'h02, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h05};
        append_ck(0);
        exp_q = '{'{1'b1, 8'd4, 8'h00}, '{1'b1, 8'd5, 8'h00}, '{1'b1, 8'd6, 8'h00}, '{1'b1, 8'd7, 8'h05}};
        exp_n = frame_q.size();
        send_frame(0, n);
        check("dmem_acc", n, exp_n);
        check_writes("dmem", 1);
        check("go_hold_before", cpu_hold, 1);
        send_byte(8'hFF, 0, acc);
        check("go_acc", acc, 1);
        check_status("go", 2'd0, 1);
        send_byte(8'h01, 0, acc);
        check("done_ignore", acc, 0);
        check_writes("done", 0);

        // Reset out of DONE, then out-of-range load.
        do_reset(1, "rst_done");
        build_load(8'h01, 8'hFE, 4, 0);
        frame_q.push_back(8'h11);
        send_frame(2, n);
        check("range_acc", n, 4);
        check_writes("range", 0);
        check_status("range", 2'd2, 0);

        // Bad command, then asynchronous reset out of ERR.
        do_reset(0, "rst_err");
        send_byte(8'h33, 0, acc);
        check("badcmd_acc", acc, 1);
        check_status("badcmd", 2'd1, 0);
        async_reset("arst_err");

        // Reset mid-frame discards the partial frame.
        frame_q = '{8'h01, 8'h10, 8'h00};
        send_frame(0, n);
        async_reset("arst_mid");
        build_load(8'h02, 8'h20, 2, 0);
        exp_n = frame_q.size();
        send_frame(1, n);
        check("after_arst_acc", n, exp_n);
        check_writes("after_arst", 0);
        check_status("after_arst", 2'd0, 0);

`ifdef BOOT_CHECKSUM_EN
        do_reset(0, "rst_ck");
        frame_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        append_ck(0);
        exp_q = '{'{1'b0, 8'd0, 8'hAA}};
        send_frame(0, n);
        check_writes("ck_ok", 0);
        check_status("ck_ok", 2'd0, 0);
        frame_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h56};
        exp_q = '{'{1'b0, 8'd0, 8'hAA}};
        send_frame(0, n);
        check_writes("ck_bad", 0);
        check_status("ck_bad", 2'd3, 0);
`endif

        // Random frame sequences with random rx_valid gaps.
        for (int r = 0; r < 25; r++) begin
            do_reset(0, "rst_rnd");
            err  = 2'd0;
            done = 0;
            nf   = $urandom_range(5, 1);
            for (int f = 0; f < nf && err == 2'd0; f++) begin
                kind   = $urandom_range(99, 0);
                cmd    = $urandom_range(1, 0) ? 8'h02 : 8'h01;
                ck_bad = 0;
                if (kind < 6) begin
                    frame_q = '{8'($urandom_range(254, 3))};
                    exp_n   = 1;
                    err     = 2'd1;
                end else if (kind < 12) begin
                    addr = $urandom_range(255, 250);
                    len  = 256 - addr + $urandom_range(5, 1);
                    build_load(cmd, addr, len, 0);
                    exp_n = 4;
                    err   = 2'd2;
                end else begin
`ifdef BOOT_CHECKSUM_EN
                    if (kind < 18) begin
                        ck_bad = 1;
                        err    = 2'd3;
                    end
`endif
                    addr = $urandom_range(255, 0);
                    len  = $urandom_range((256 - addr < 8) ? 256 - addr : 8, 0);
                    build_load(cmd, addr, len, ck_bad);
                    exp_n = frame_q.size();
                end
                send_frame(3, n);
                check("rnd_acc", n, exp_n);
            end
            if (err == 2'd0 && $urandom_range(1, 0) == 1) begin
                send_byte(8'hFF, 3, acc);
                check("rnd_go_acc", acc, 1);
                done = 1;
            end
            check_writes("rnd", 0);
            check_status("rnd", err, done);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
